// File: rtl/weird_mult_pkg.sv
// Shared types and constants for the weird_mult_sched squaring-unit scheduler.
package weird_mult_pkg;

    localparam int unsigned SEED_W        = 8;
    localparam int unsigned NREQ_DEFAULT  = 4;
    localparam int unsigned CNT_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StDrain,
        StResp
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: grants the first requester at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] ptr_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic [$clog2(NREQ)-1:0] gnt_idx_o,
    output logic                    gnt_valid_o
);

    localparam int unsigned IdxW = $clog2(NREQ);

    // Scan NREQ positions starting at the pointer; the first hit wins.
    always_comb begin
        logic        found;
        int unsigned idx;
        found       = 1'b0;
        idx         = 0;
        gnt_o       = '0;
        gnt_idx_o   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr_i) + k) % NREQ;
            if (!found && req_i[idx]) begin
                found          = 1'b1;
                gnt_o[idx]     = 1'b1;
                gnt_idx_o      = IdxW'(idx);
            end
        end
        gnt_valid_o = found;
    end

endmodule

// File: rtl/weird_mult_sched.sv
// Round-robin scheduler sharing one iterative 8-bit squarer between NREQ requesters.
// Optional feature: define WMS_ABORT_EN to add an `abort` input that cancels an in-flight job.
module weird_mult_sched
    import weird_mult_pkg::*;
#(
    parameter int unsigned NREQ     = NREQ_DEFAULT,
    parameter int unsigned CNT_W    = CNT_W_DEFAULT,
    parameter int unsigned SQ_DRAIN = 1
) (
    input  logic                      clk,
    input  logic                      rst,
`ifdef WMS_ABORT_EN
    input  logic                      abort,
`endif
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*SEED_W-1:0]    req_seed,
    input  logic [NREQ*CNT_W-1:0]     req_iter,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [SEED_W-1:0]         rsp_data,
    output logic                      busy,
    output logic                      sq_rst,
    output logic                      sq_load,
    output logic                      sq_enable,
    output logic [SEED_W-1:0]         sq_data_in,
    input  logic [SEED_W-1:0]         sq_data_out
);

    localparam int unsigned IdxW = $clog2(NREQ);
    localparam int unsigned DrW  = $clog2(SQ_DRAIN + 1);

    state_e             state_q;
    logic [IdxW-1:0]    rr_ptr_q;
    logic [IdxW-1:0]    g_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   iter_q;
    logic [SEED_W-1:0]  seed_q;
    logic [SEED_W-1:0]  rsp_data_q;
    logic [DrW-1:0]     drain_q;

    logic [NREQ-1:0]    gnt;
    logic [IdxW-1:0]    gnt_idx;
    logic               gnt_valid;
    logic [SEED_W-1:0]  sel_seed;
    logic [CNT_W-1:0]   sel_iter;
    logic [IdxW-1:0]    next_ptr;
    logic               abort_w;
    logic               abort_act;

`ifdef WMS_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req_i       (req_valid),
        .ptr_i       (rr_ptr_q),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    // Select the granted requester's seed and iteration count.
    always_comb begin
        sel_seed = req_seed[32'(gnt_idx) * SEED_W +: SEED_W];
        sel_iter = req_iter[32'(gnt_idx) * CNT_W +: CNT_W];
        next_ptr = (g_q == IdxW'(NREQ - 1)) ? '0 : g_q + 1'b1;
    end

    // Abort only acts while the squarer is owned by a job.
    assign abort_act = abort_w &&
                       (state_q == StLoad || state_q == StRun || state_q == StDrain);

    // Main job FSM: grant, load, step, drain, respond.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            g_q        <= '0;
            cnt_q      <= '0;
            iter_q     <= '0;
            seed_q     <= '0;
            rsp_data_q <= '0;
            drain_q    <= '0;
        end else if (abort_act) begin
            state_q  <= StIdle;
            rr_ptr_q <= next_ptr;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (gnt_valid) begin
                        seed_q  <= sel_seed;
                        iter_q  <= sel_iter;
                        g_q     <= gnt_idx;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    if (iter_q == '0) begin
                        rsp_data_q <= seed_q;
                        state_q    <= StResp;
                    end else begin
                        cnt_q   <= iter_q;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                    if (cnt_q == CNT_W'(1)) begin
                        drain_q <= DrW'(SQ_DRAIN - 1);
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (drain_q == '0) begin
                        rsp_data_q <= sq_data_out;
                        state_q    <= StResp;
                    end else begin
                        drain_q <= drain_q - 1'b1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rr_ptr_q <= next_ptr;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Outputs decoded from registered state; strobes are masked while aborting.
    always_comb begin
        req_ready  = (state_q == StIdle && !rst) ? gnt : '0;
        rsp_valid  = (state_q == StResp);
        rsp_id     = g_q;
        rsp_data   = rsp_data_q;
        busy       = (state_q != StIdle);
        sq_rst     = rst || abort_act;
        sq_load    = (state_q == StLoad) && !abort_act;
        sq_enable  = (state_q == StRun) && !abort_act;
        sq_data_in = (state_q == StLoad) ? seed_q : '0;
    end

endmodule
